// File: rtl/ifu_ifu2icb_multi_pkg.sv
// ---------------------------------------------------------------------------
// ifu_ifu2icb_multi_pkg
// Shared definitions for the IFU-to-ICB fetch router:
//   - default fetch address / data widths
//   - encoding of the internal error target (unmapped fetch addresses)
//   - layout of one entry in the outstanding-fetch FIFO
// No ports; imported by ifu_outs_fifo and ifu_ifu2icb_multi.
// ---------------------------------------------------------------------------
package ifu_ifu2icb_multi_pkg;

  localparam int IFU_AW_DEF = 32;
  localparam int IFU_DW_DEF = 32;

  // Target ids fit in 4 bits since at most 8 real targets exist (ids 0..7).
  // Id 8 is never a real target and marks the internal error target.
  localparam int TGT_IDW = 4;
  localparam logic [TGT_IDW-1:0] ERR_TGT_ID = 4'd8;

  // Payload of one outstanding fetch. The kill flag is kept by the FIFO
  // itself because it has to be set on every live entry at once.
  typedef struct packed {
    logic [TGT_IDW-1:0] tgtId;
    logic               isErr;
  } outs_entry_t;

  localparam int ENTRY_W = TGT_IDW + 1;

endpackage

// File: rtl/ifu_outs_fifo.sv
// ---------------------------------------------------------------------------
// ifu_outs_fifo
// In-order FIFO of outstanding fetches, with a per-entry kill flag that can
// be set on all entries in one cycle (used by a fetch flush).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push          write i_pushData at the tail (ignored when full)
//   i_pushData      entry payload, W bits
//   i_pop           drop the head entry (ignored when empty)
//   i_killAll       mark every stored entry as killed
//   o_headData      payload of the head entry
//   o_headKill      kill flag of the head entry
//   o_full/o_empty  occupancy flags from the occupancy counter
// ---------------------------------------------------------------------------
module ifu_outs_fifo import ifu_ifu2icb_multi_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_pushData,
  input  logic         i_pop,
  input  logic         i_killAll,
  output logic [W-1:0] o_headData,
  output logic         o_headKill,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers wrap at DEPTH-1 rather than at a power of two, so any depth works.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_doPush   = i_push & ~o_full;
  assign w_doPop    = i_pop & ~o_empty;
  assign o_headData = r_mem[r_rdPtr];
  assign o_headKill = r_kill[r_rdPtr];

  // Storage, pointers and occupancy. A kill-all marks every slot; a slot
  // being written in the same cycle starts life un-killed. Free slots may
  // carry a stale kill flag, which is harmless because a push clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_kill  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_killAll) r_kill <= '1;
      if (w_doPush) begin
        r_mem[r_wrPtr]  <= i_pushData;
        r_kill[r_wrPtr] <= 1'b0;
        r_wrPtr         <= nextPtr(r_wrPtr);
      end
      if (w_doPop) r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_ifu2icb_multi.sv
// ---------------------------------------------------------------------------
// ifu_ifu2icb_multi
// Routes instruction fetches to one of N_TGT ICB targets by address decode
// and returns the responses to the IFU strictly in request order. Fetches to
// unmapped addresses go to an internal error target that answers with
// err=1, rdata=0. A flush discards every response still outstanding.
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   ifu_req_valid/ready/addr               fetch request channel
//   ifu_flush                              discard outstanding responses
//   ifu_rsp_valid/ready/rdata/err          fetch response channel
//   tgt_cmd_valid/ready/addr               per-target ICB command (addr broadcast)
//   tgt_rsp_valid/ready/rdata/err          per-target ICB response
// ---------------------------------------------------------------------------
module ifu_ifu2icb_multi import ifu_ifu2icb_multi_pkg::*; #(
  parameter int AW         = IFU_AW_DEF,
  parameter int DW         = IFU_DW_DEF,
  parameter int N_TGT      = 2,
  parameter int OUTS_DEPTH = 2,
  parameter logic [N_TGT*AW-1:0] TGT_BASE = {32'h8000_0000, 32'h0000_0000},
  parameter logic [N_TGT*AW-1:0] TGT_MASK = {32'hFFF0_0000, 32'h8000_0000}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [AW-1:0]       ifu_req_addr,
  input  logic                ifu_flush,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DW-1:0]       ifu_rsp_rdata,
  output logic                ifu_rsp_err,
  output logic [N_TGT-1:0]    tgt_cmd_valid,
  input  logic [N_TGT-1:0]    tgt_cmd_ready,
  output logic [N_TGT*AW-1:0] tgt_cmd_addr,
  input  logic [N_TGT-1:0]    tgt_rsp_valid,
  output logic [N_TGT-1:0]    tgt_rsp_ready,
  input  logic [N_TGT*DW-1:0] tgt_rsp_rdata,
  input  logic [N_TGT-1:0]    tgt_rsp_err
);

  logic [TGT_IDW-1:0] w_selId;
  logic               w_selErr;
  logic [N_TGT-1:0]   w_selOneHot;
  logic               w_selCmdReady;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_headKill;
  outs_entry_t        w_pushEntry;
  outs_entry_t        w_head;

  // Address decode. Scanning from the highest index down lets the lowest
  // matching target overwrite the others, so the lowest hit wins. Only the
  // winner is offered the command, so overlapping windows never issue twice.
  always_comb begin
    w_selId       = ERR_TGT_ID;
    w_selErr      = 1'b1;
    w_selOneHot   = '0;
    w_selCmdReady = 1'b1;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if ((ifu_req_addr & TGT_MASK[i*AW +: AW]) ==
          (TGT_BASE[i*AW +: AW] & TGT_MASK[i*AW +: AW])) begin
        w_selId       = TGT_IDW'(i);
        w_selErr      = 1'b0;
        w_selOneHot   = '0;
        w_selOneHot[i] = 1'b1;
        w_selCmdReady = tgt_cmd_ready[i];
      end
    end
  end

  // Command side. Ready depends only on the registered occupancy, so a pop
  // in the same cycle does not free a slot for a push until the next cycle.
  assign ifu_req_ready = ~w_full & ~ifu_flush & w_selCmdReady;
  assign w_push        = ifu_req_valid & ifu_req_ready;
  assign tgt_cmd_valid = (ifu_req_valid & ~w_full & ~ifu_flush) ? w_selOneHot : '0;
  assign tgt_cmd_addr  = {N_TGT{ifu_req_addr}};

  assign w_pushEntry.tgtId = w_selId;
  assign w_pushEntry.isErr = w_selErr;

  ifu_outs_fifo #(
    .DEPTH (OUTS_DEPTH),
    .W     (ENTRY_W)
  ) u_outsFifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData (w_pushEntry),
    .i_pop      (w_pop),
    .i_killAll  (ifu_flush),
    .o_headData (w_head),
    .o_headKill (w_headKill),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Response side. Only the target at the FIFO head is listened to, which
  // keeps responses in request order. A killed head is drained silently:
  // real targets are acked as soon as they answer, and the error target is
  // dropped at once since it has nothing to wait for.
  always_comb begin
    ifu_rsp_valid = 1'b0;
    ifu_rsp_rdata = '0;
    ifu_rsp_err   = 1'b0;
    tgt_rsp_ready = '0;
    w_pop         = 1'b0;
    if (!w_empty) begin
      if (w_head.isErr) begin
        ifu_rsp_valid = ~w_headKill;
        ifu_rsp_err   = ~w_headKill;
        w_pop         = w_headKill | ifu_rsp_ready;
      end else begin
        for (int i = 0; i < N_TGT; i++) begin
          if (w_head.tgtId == TGT_IDW'(i)) begin
            if (w_headKill) begin
              tgt_rsp_ready[i] = 1'b1;
              w_pop            = tgt_rsp_valid[i];
            end else begin
              ifu_rsp_valid    = tgt_rsp_valid[i];
              ifu_rsp_rdata    = tgt_rsp_rdata[i*DW +: DW];
              ifu_rsp_err      = tgt_rsp_err[i];
              tgt_rsp_ready[i] = ifu_rsp_ready;
              w_pop            = tgt_rsp_valid[i] & ifu_rsp_ready;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_ifu2icb_multi.sv
// ---------------------------------------------------------------------------
// tb_ifu_ifu2icb_multi
// Directed scenarios for the fetch router followed by randomized traffic
// checked against a queue-based model of outstanding fetches.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_ifu_ifu2icb_multi;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_flush;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        ifu_rsp_err;
  logic [1:0]  tgt_cmd_valid;
  logic [1:0]  tgt_cmd_ready;
  logic [63:0] tgt_cmd_addr;
  logic [1:0]  tgt_rsp_valid;
  logic [1:0]  tgt_rsp_ready;
  logic [63:0] tgt_rsp_rdata;
  logic [1:0]  tgt_rsp_err;

  int errors = 0;
  int checks = 0;

  // One outstanding fetch in the model: target 0 = Sys-MEM, 1 = ITCM, 2 = error.
  typedef struct {
    int tgt;
    bit killed;
  } ent_t;

  ifu_ifu2icb_multi dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_flush     (ifu_flush),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .tgt_cmd_valid (tgt_cmd_valid),
    .tgt_cmd_ready (tgt_cmd_ready),
    .tgt_cmd_addr  (tgt_cmd_addr),
    .tgt_rsp_valid (tgt_rsp_valid),
    .tgt_rsp_ready (tgt_rsp_ready),
    .tgt_rsp_rdata (tgt_rsp_rdata),
    .tgt_rsp_err   (tgt_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory map with default parameters: Sys-MEM below 2 GiB, ITCM 1 MiB at 0x8000_0000.
  function automatic int refDecode(input logic [31:0] a);
    if (a < 32'h8000_0000) return 0;
    if (a < 32'h8010_0000) return 1;
    return 2;
  endfunction

  // Drive one cycle of inputs on the falling edge, then settle.
  task automatic applyStimulus(input logic rv, input logic [31:0] a, input logic fl,
                               input logic rr, input logic [1:0] tv,
                               input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    ifu_req_valid = rv;
    ifu_req_addr  = a;
    ifu_flush     = fl;
    ifu_rsp_ready = rr;
    tgt_rsp_valid = tv;
    tgt_rsp_rdata = {d1, d0};
    tgt_rsp_err   = 2'b00;
    tgt_cmd_ready = 2'b11;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_flush = 1'b0; ifu_rsp_ready = 1'b1;
    tgt_cmd_ready = 2'b11; tgt_rsp_valid = 2'b00; tgt_rsp_rdata = '0; tgt_rsp_err = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (tgt_cmd_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_cmd_valid got=%b exp=00", tgt_cmd_valid); end
    checks++; if (tgt_rsp_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_tgt_rsp_ready got=%b exp=00", tgt_rsp_ready); end
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=1", ifu_req_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_itcm_fetch();
    applyStimulus(1'b1, 32'h8000_0010, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (tgt_cmd_valid !== 2'b10) begin errors++; $display("[TB] FAIL itcm_cmd_valid got=%b exp=10", tgt_cmd_valid); end
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL itcm_req_ready got=%b exp=1", ifu_req_ready); end
    checks++; if (tgt_cmd_addr !== {2{32'h8000_0010}}) begin errors++; $display("[TB] FAIL itcm_cmd_addr got=%h exp=%h", tgt_cmd_addr, {2{32'h8000_0010}}); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h1234_5678);
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL itcm_rsp_valid got=%b exp=1", ifu_rsp_valid); end
    checks++; if (ifu_rsp_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL itcm_rdata got=%h exp=12345678", ifu_rsp_rdata); end
    checks++; if (ifu_rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL itcm_err got=%b exp=0", ifu_rsp_err); end
    checks++; if (tgt_rsp_ready !== 2'b10) begin errors++; $display("[TB] FAIL itcm_tgt_rsp_ready got=%b exp=10", tgt_rsp_ready); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL itcm_drained got=%b exp=0", ifu_rsp_valid); end
  endtask

  task automatic test_ordering();
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (tgt_cmd_valid !== 2'b01) begin errors++; $display("[TB] FAIL order_cmd_sys got=%b exp=01", tgt_cmd_valid); end
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (tgt_cmd_valid !== 2'b10) begin errors++; $display("[TB] FAIL order_cmd_itcm got=%b exp=10", tgt_cmd_valid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 32'h0, 32'hAAAA_0001);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_early_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (tgt_rsp_ready !== 2'b01) begin errors++; $display("[TB] FAIL order_early_ready got=%b exp=01", tgt_rsp_ready); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b11, 32'h5555_0002, 32'hAAAA_0001);
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL order_sys_valid got=%b exp=1", ifu_rsp_valid); end
    checks++; if (ifu_rsp_rdata !== 32'h5555_0002) begin errors++; $display("[TB] FAIL order_sys_rdata got=%h exp=55550002", ifu_rsp_rdata); end
    checks++; if (tgt_rsp_ready !== 2'b01) begin errors++; $display("[TB] FAIL order_sys_ready got=%b exp=01", tgt_rsp_ready); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 32'h0, 32'hAAAA_0001);
    checks++; if (ifu_rsp_rdata !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL order_itcm_rdata got=%h exp=aaaa0001", ifu_rsp_rdata); end
    checks++; if (tgt_rsp_ready !== 2'b10) begin errors++; $display("[TB] FAIL order_itcm_ready got=%b exp=10", tgt_rsp_ready); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_drained got=%b exp=0", ifu_rsp_valid); end
  endtask

  task automatic test_unmapped();
    applyStimulus(1'b1, 32'h9000_0000, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (tgt_cmd_valid !== 2'b00) begin errors++; $display("[TB] FAIL unmap_cmd_valid got=%b exp=00", tgt_cmd_valid); end
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL unmap_req_ready got=%b exp=1", ifu_req_ready); end
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL unmap_same_cycle got=%b exp=0", ifu_rsp_valid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL unmap_rsp_valid got=%b exp=1", ifu_rsp_valid); end
    checks++; if (ifu_rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL unmap_err got=%b exp=1", ifu_rsp_err); end
    checks++; if (ifu_rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL unmap_rdata got=%h exp=0", ifu_rsp_rdata); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL unmap_drained got=%b exp=0", ifu_rsp_valid); end
  endtask

  task automatic test_full();
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_second_ready got=%b exp=1", ifu_req_ready); end
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got=%b exp=0", ifu_req_ready); end
    checks++; if (tgt_cmd_valid !== 2'b00) begin errors++; $display("[TB] FAIL full_cmd_valid got=%b exp=00", tgt_cmd_valid); end
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b1, 2'b01, 32'h1111_1111, 32'h0);
    checks++; if (ifu_rsp_rdata !== 32'h1111_1111) begin errors++; $display("[TB] FAIL full_pop_rdata got=%h exp=11111111", ifu_rsp_rdata); end
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_same_cycle got=%b exp=0", ifu_req_ready); end
    applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_next_cycle got=%b exp=1", ifu_req_ready); end
    checks++; if (tgt_cmd_valid !== 2'b01) begin errors++; $display("[TB] FAIL full_refill_cmd got=%b exp=01", tgt_cmd_valid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b01, 32'h2222_2222, 32'h0);
    checks++; if (ifu_rsp_rdata !== 32'h2222_2222) begin errors++; $display("[TB] FAIL full_drain1 got=%h exp=22222222", ifu_rsp_rdata); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b01, 32'h3333_3333, 32'h0);
    checks++; if (ifu_rsp_rdata !== 32'h3333_3333) begin errors++; $display("[TB] FAIL full_drain2 got=%h exp=33333333", ifu_rsp_rdata); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drained got=%b exp=0", ifu_rsp_valid); end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h8000_0040, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0600, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_ready got=%b exp=0", ifu_req_ready); end
    checks++; if (tgt_cmd_valid !== 2'b00) begin errors++; $display("[TB] FAIL flush_cmd_valid got=%b exp=00", tgt_cmd_valid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b11, 32'hDEAD_0001, 32'hDEAD_0002);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_killed1_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (tgt_rsp_ready !== 2'b01) begin errors++; $display("[TB] FAIL flush_killed1_ready got=%b exp=01", tgt_rsp_ready); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 32'h0, 32'hDEAD_0002);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_killed2_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (tgt_rsp_ready !== 2'b10) begin errors++; $display("[TB] FAIL flush_killed2_ready got=%b exp=10", tgt_rsp_ready); end
    applyStimulus(1'b1, 32'h8000_0080, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (tgt_cmd_valid !== 2'b10) begin errors++; $display("[TB] FAIL flush_new_cmd got=%b exp=10", tgt_cmd_valid); end
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got=%b exp=0", ifu_rsp_valid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b10, 32'h0, 32'hCAFE_0003);
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_new_valid got=%b exp=1", ifu_rsp_valid); end
    checks++; if (ifu_rsp_rdata !== 32'hCAFE_0003) begin errors++; $display("[TB] FAIL flush_new_rdata got=%h exp=cafe0003", ifu_rsp_rdata); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    applyStimulus(1'b1, 32'h0000_0700, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h8000_0100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 32'h7777_7777, 32'h0);
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_before got=%b exp=1", ifu_rsp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async_valid got=%b exp=0", ifu_rsp_valid); end
    checks++; if (tgt_rsp_ready !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_async_ready got=%b exp=00", tgt_rsp_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_req_ready got=%b exp=1", ifu_req_ready); end
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rsp_valid got=%b exp=0", ifu_rsp_valid); end
    applyStimulus(1'b1, 32'h9000_0000, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    checks++; if (ifu_rsp_err !== 1'b1 || ifu_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_fresh_head got=%b%b exp=11", ifu_rsp_valid, ifu_rsp_err); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    int dt;
    bit pend, pop, push, expReady, expValid, expErr;
    logic [1:0] expCmd, expRspReady;
    logic [31:0] expRdata;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      ifu_flush     = ($urandom_range(0, 11) == 0);
      ifu_req_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ifu_req_addr = {1'b0, 31'($urandom)};
        1:       ifu_req_addr = 32'h8000_0000 + 32'($urandom_range(0, 32'h000F_FFFF));
        default: ifu_req_addr = 32'h9000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
      endcase
      tgt_cmd_ready = 2'($urandom);
      ifu_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int t = 0; t < 2; t++) begin
        pend = 0;
        foreach (q[k]) if (q[k].tgt == t) pend = 1;
        tgt_rsp_valid[t] = pend && ($urandom_range(0, 1) == 1);
      end
      tgt_rsp_rdata = {$urandom, $urandom};
      tgt_rsp_err   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      #1;
      dt = refDecode(ifu_req_addr);
      expReady = (q.size() < DEPTH) && !ifu_flush;
      if (dt != 2) expReady = expReady && tgt_cmd_ready[dt];
      expCmd = 2'b00;
      if (ifu_req_valid && dt != 2 && q.size() < DEPTH && !ifu_flush) expCmd[dt] = 1'b1;
      expValid = 0; expErr = 0; expRdata = '0; expRspReady = 2'b00; pop = 0;
      if (q.size() > 0) begin
        e = q[0];
        if (e.tgt == 2) begin
          expValid = !e.killed; expErr = !e.killed;
          pop = e.killed || ifu_rsp_ready;
        end else if (e.killed) begin
          expRspReady[e.tgt] = 1'b1;
          pop = tgt_rsp_valid[e.tgt];
        end else begin
          expValid = tgt_rsp_valid[e.tgt];
          expRdata = tgt_rsp_rdata[e.tgt*32 +: 32];
          expErr   = tgt_rsp_err[e.tgt];
          expRspReady[e.tgt] = ifu_rsp_ready;
          pop = tgt_rsp_valid[e.tgt] && ifu_rsp_ready;
        end
      end
      checks++; if (ifu_req_ready !== expReady) begin errors++; $display("[TB] FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, ifu_req_ready, expReady); end
      checks++; if (tgt_cmd_valid !== expCmd) begin errors++; $display("[TB] FAIL rnd_cmd_valid cyc=%0d got=%b exp=%b", cyc, tgt_cmd_valid, expCmd); end
      checks++; if (tgt_cmd_addr !== {2{ifu_req_addr}}) begin errors++; $display("[TB] FAIL rnd_cmd_addr cyc=%0d got=%h exp=%h", cyc, tgt_cmd_addr, {2{ifu_req_addr}}); end
      checks++; if (ifu_rsp_valid !== expValid) begin errors++; $display("[TB] FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, ifu_rsp_valid, expValid); end
      checks++; if (tgt_rsp_ready !== expRspReady) begin errors++; $display("[TB] FAIL rnd_tgt_rsp_ready cyc=%0d got=%b exp=%b", cyc, tgt_rsp_ready, expRspReady); end
      if (expValid) begin
        checks++; if (ifu_rsp_rdata !== expRdata || ifu_rsp_err !== expErr) begin errors++; $display("[TB] FAIL rnd_rsp_data cyc=%0d got=%h/%b exp=%h/%b", cyc, ifu_rsp_rdata, ifu_rsp_err, expRdata, expErr); end
      end
      push = ifu_req_valid && expReady;
      if (ifu_flush) foreach (q[k]) q[k].killed = 1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{tgt: dt, killed: 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_itcm_fetch();
    test_ordering();
    test_unmapped();
    test_full();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_ifu2icb_multi.md
IFU_IFU2ICB_MULTI -- requirements
Module: ifu_ifu2icb_multi

Interface
REQ-001 SHALL have parameter AW, default 32, meaning fetch address width.
REQ-002 SHALL have parameter DW, default 32, meaning fetch data width.
REQ-003 SHALL have parameter N_TGT, default 2, range 1-8, meaning number of ICB target ports (ITCM, Sys-MEM, ...).
REQ-004 SHALL have parameter OUTS_DEPTH, default 2, range 1-8, meaning maximum outstanding fetches.
REQ-005 SHALL have parameter TGT_BASE, default {32'h8000_0000, 32'h0000_0000}, meaning per-target base addresses, N_TGT*AW bits, target 0 in LSBs.
REQ-006 SHALL have parameter TGT_MASK, default {32'hFFF0_0000, 32'h8000_0000}, meaning per-target address-match masks, N_TGT*AW bits.
REQ-007 Port list: clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-008 Port list: rst  in  1  reset; asynchronous, active-high.
REQ-009 Port list: ifu_req_valid in 1, ifu_req_ready out 1, ifu_req_addr in AW  fetch request channel.
REQ-010 Port list: ifu_flush  in  1  discard all responses outstanding at this edge.
REQ-011 Port list: ifu_rsp_valid out 1, ifu_rsp_ready in 1, ifu_rsp_rdata out DW, ifu_rsp_err out 1  fetch response channel.
REQ-012 Port list: tgt_cmd_valid out N_TGT, tgt_cmd_ready in N_TGT, tgt_cmd_addr out N_TGT*AW  per-target ICB command.
REQ-013 Port list: tgt_rsp_valid in N_TGT, tgt_rsp_ready out N_TGT, tgt_rsp_rdata in N_TGT*DW, tgt_rsp_err in N_TGT  per-target ICB response.

Function
REQ-014 Decode SHALL be combinational: target i hits when (ifu_req_addr & MASK_i) == (BASE_i & MASK_i); the lowest hit index wins; no hit selects the internal error target.
REQ-015 Handshake rules, command side:
- tgt_cmd_valid[i] SHALL be ifu_req_valid & hit_i & !fifo_full & !ifu_flush.
- tgt_cmd_addr SHALL broadcast ifu_req_addr to all targets.
REQ-016 ifu_req_ready SHALL be !fifo_full & !ifu_flush & (selected tgt_cmd_ready, or 1 for the error target); no pushes while full, even with a simultaneous pop.
REQ-017 Each accepted request SHALL push {tgt_id, is_err, kill=0} into an in-order outstanding FIFO of depth OUTS_DEPTH.
REQ-018 Responses SHALL return strictly in request order: only the FIFO-head target's rsp is observed; tgt_rsp_ready SHALL be 0 for all non-head targets.
REQ-019 Head is a real target, kill=0: ifu_rsp_valid, rdata and err SHALL pass through combinationally; tgt_rsp_ready[head] = ifu_rsp_ready; pop on tgt_rsp_valid & ifu_rsp_ready.
REQ-020 Head is the error target, kill=0: ifu_rsp_valid=1, rdata=0, err=1; pop on ifu_rsp_ready; minimum latency 1 cycle after acceptance.
REQ-021 Head has kill=1: ifu_rsp_valid SHALL be 0; tgt_rsp_ready[head]=1; pop on tgt_rsp_valid, or immediately for the error target.
REQ-022 Flush: on an edge where ifu_flush=1, every valid FIFO entry SHALL get kill=1; no new request is accepted that cycle; the next cycle accepts normally.
REQ-023 Pointers SHALL wrap modulo OUTS_DEPTH; full/empty SHALL come from an occupancy counter of width $clog2(OUTS_DEPTH+1).

Reset
REQ-024 Reset value of every output: rst SHALL clear the FIFO, counter and pointers asynchronously, so ifu_rsp_valid, tgt_cmd_valid and tgt_rsp_ready are 0, and ifu_req_ready follows REQ-016 with an empty FIFO.
REQ-025 Reset mid-operation SHALL drop all outstanding entries; late target responses after reset are the system's responsibility (targets are reset together).

Structure
REQ-026 Shared header defines.v SHALL hold the fetch address/data width defaults and the error-target encoding constant.
REQ-027 The outstanding FIFO SHALL be a sub-module ifu_outs_fifo (params DEPTH, W), with push/pop/full/empty and a kill-all input.

Verification
REQ-028 Scenario, ITCM fetch: defaults, addr 0x8000_0010, ITCM rsp 0x1234_5678 after 1 cycle -> ifu_rsp_valid with rdata 0x1234_5678, err=0.
REQ-029 Scenario, ordering: fetch Sys-MEM 0x0000_0100, then ITCM 0x8000_0000; ITCM responds first -> ITCM rsp_ready=0 until Sys-MEM data is delivered, then ITCM data.
REQ-030 Scenario, unmapped address: addr 0x9000_0000 (default masks) -> ifu_rsp_err=1, rdata=0 one cycle after acceptance; no tgt_cmd_valid asserted.
REQ-031 Scenario, full: OUTS_DEPTH=2, two accepted and none returned -> ifu_req_ready=0; pop one -> ready=1 the next cycle, not the same cycle.
REQ-032 Scenario, flush: two outstanding, ifu_flush pulse, then both responses arrive -> ifu_rsp_valid stays 0; a new fetch issued after flush returns its data normally.
REQ-033 Scenario, reset mid-flight: assert rst with 2 outstanding -> ifu_rsp_valid=0 immediately (asynchronous); after release, FIFO empty and ifu_req_ready=1.
